// File: rtl/timer_peripheral.sv
// ---------------------------------------------------------------------------
// timer_peripheral
//
// Memory-mapped I/O block on the CPU data-memory bus.
// It contains the following registers:
//   - an interval timer (TH / TL / TCON) that raises a level interrupt on overflow
//   - an LED output register
//   - a registered switch input
//   - a 7-segment digit register
//   - a free-running tick counter
//
// Register map (word offsets from BASE_ADDR):
//   0x00 TH      R/W  reload value
//   0x04 TL      R/W  counter
//   0x08 TCON    R/W  [0] enable, [1] irq enable, [2] irq status
//   0x0C led     R/W
//   0x10 switch  RO   switch value sampled one cycle earlier
//   0x14 digi    R/W  {AN[3:0], seg[7:0]}
//   0x18 systick RO
//
// Ports:
//   clk     system clock
//   reset   asynchronous active-low reset
//   rd, wr  read / write strobes from the MEM stage
//   addr    byte address (word aligned; addr[1:0] ignored)
//   wdata   store data
//   rdata   combinational load data (0 when not reading a mapped register)
//   switch  board switches
//   led     LED register
//   digi    digit register
//   irqout  registered timer interrupt request
// ---------------------------------------------------------------------------
module timer_peripheral #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          LED_W     = 8,
  parameter int          SW_W      = 8,
  parameter int          DIGI_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [SW_W-1:0]   switch,
  output logic [LED_W-1:0]  led,
  output logic [DIGI_W-1:0] digi,
  output logic              irqout
);

  // Word offsets within the peripheral window
  localparam logic [5:0] OFF_TH   = 6'd0;
  localparam logic [5:0] OFF_TL   = 6'd1;
  localparam logic [5:0] OFF_TCON = 6'd2;
  localparam logic [5:0] OFF_LED  = 6'd3;
  localparam logic [5:0] OFF_SW   = 6'd4;
  localparam logic [5:0] OFF_DIGI = 6'd5;
  localparam logic [5:0] OFF_TICK = 6'd6;

  logic [31:0]       th_q,   th_d;
  logic [31:0]       tl_q,   tl_d;
  logic [2:0]        tcon_q, tcon_d;
  logic [LED_W-1:0]  led_q,  led_d;
  logic [DIGI_W-1:0] digi_q, digi_d;
  logic [SW_W-1:0]   sw_q,   sw_d;
  logic [31:0]       tick_q, tick_d;
  logic              irq_q,  irq_d;

  logic       regHit;
  logic [5:0] wordSel;
  logic       overflow;
  logic       statusSet;
  logic [1:0] unusedAddrBits;

  assign regHit         = (addr[31:8] == BASE_ADDR[31:8]);
  assign wordSel        = addr[7:2];
  assign unusedAddrBits = addr[1:0];

  // Overflow is judged on the current TL, so a same-edge CPU write to TL
  // still lets the status bit set while the write value wins the counter.
  assign overflow  = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
  assign statusSet = overflow && tcon_q[1];

  // Next-state logic: timer behaviour first, then CPU writes override.
  // A TCON write ORs in a coinciding status event so an overflow is never lost.
  // A TH write does not affect a reload on the same edge, since the reload
  // reads th_q.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    led_d  = led_q;
    digi_d = digi_q;
    sw_d   = switch;
    tick_d = tick_q + 32'd1;
    irq_d  = tcon_q[1] & tcon_q[2];

    if (tcon_q[0]) begin
      tl_d = overflow ? th_q : (tl_q + 32'd1);
    end
    if (statusSet) begin
      tcon_d[2] = 1'b1;
    end

    if (wr && regHit) begin
      case (wordSel)
        OFF_TH:   th_d   = wdata;
        OFF_TL:   tl_d   = wdata;
        OFF_TCON: tcon_d = {wdata[2] | statusSet, wdata[1:0]};
        OFF_LED:  led_d  = wdata[LED_W-1:0];
        OFF_DIGI: digi_d = wdata[DIGI_W-1:0];
        default:  ;
      endcase
    end
  end

  // State register: asynchronous clear of every register on reset low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
      led_q  <= '0;
      digi_q <= '0;
      sw_q   <= '0;
      tick_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      led_q  <= led_d;
      digi_q <= digi_d;
      sw_q   <= sw_d;
      tick_q <= tick_d;
      irq_q  <= irq_d;
    end
  end

  // Combinational read mux. On rd and wr together this shows the pre-write value.
  always_comb begin
    rdata = 32'h0;
    if (rd && regHit) begin
      case (wordSel)
        OFF_TH:   rdata = th_q;
        OFF_TL:   rdata = tl_q;
        OFF_TCON: rdata = {29'h0, tcon_q};
        OFF_LED:  rdata = 32'(led_q);
        OFF_SW:   rdata = 32'(sw_q);
        OFF_DIGI: rdata = 32'(digi_q);
        OFF_TICK: rdata = tick_q;
        default:  rdata = 32'h0;
      endcase
    end
  end

  assign led    = led_q;
  assign digi   = digi_q;
  assign irqout = irq_q;

endmodule

// File: tb/tb_timer_peripheral.sv
// ---------------------------------------------------------------------------
// tb_timer_peripheral
//
// Drives bus transactions into timer_peripheral. A behavioural model of the
// register map predicts every load result and every output.
// ---------------------------------------------------------------------------
module tb_timer_peripheral;

  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [31:0] A_TH   = BASE + 32'h00;
  localparam logic [31:0] A_TL   = BASE + 32'h04;
  localparam logic [31:0] A_TCON = BASE + 32'h08;
  localparam logic [31:0] A_LED  = BASE + 32'h0C;
  localparam logic [31:0] A_SW   = BASE + 32'h10;
  localparam logic [31:0] A_DIGI = BASE + 32'h14;
  localparam logic [31:0] A_TICK = BASE + 32'h18;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        rd     = 1'b0;
  logic        wr     = 1'b0;
  logic [31:0] addr   = 32'h0;
  logic [31:0] wdata  = 32'h0;
  logic [7:0]  switch = 8'h0;
  logic [31:0] rdata;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irqout;

  int checks   = 0;
  int failures = 0;

  // Model state
  logic [31:0] mTh, mTl, mTick;
  logic [2:0]  mTcon;
  logic [7:0]  mLed, mSw;
  logic [11:0] mDigi;
  logic        mIrq;

  logic [31:0] sampledRdata;
  logic [31:0] expRdata;

  timer_peripheral dut (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .switch (switch),
    .led    (led),
    .digi   (digi),
    .irqout (irqout)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mTh = 0; mTl = 0; mTick = 0; mTcon = 0;
    mLed = 0; mSw = 0; mDigi = 0; mIrq = 0;
  endtask

  // What a load should return, given the model state
  function automatic logic [31:0] modelRead(input logic r, input logic [31:0] a);
    if (!r || a[31:8] != BASE[31:8]) return 32'h0;
    case (a[7:0] & 8'hFC)
      8'h00:   return mTh;
      8'h04:   return mTl;
      8'h08:   return {29'h0, mTcon};
      8'h0C:   return {24'h0, mLed};
      8'h10:   return {24'h0, mSw};
      8'h14:   return {20'h0, mDigi};
      8'h18:   return mTick;
      default: return 32'h0;
    endcase
  endfunction

  // One clock of the peripheral's rules.
  // The timer counts or reloads, a pending overflow raises status, and a CPU
  // store then takes precedence, except that status events are never dropped.
  task automatic modelEdge(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [7:0] sw);
    logic        wrapNow;
    logic        raise;
    logic [31:0] nextTl;
    logic [2:0]  nextTcon;
    logic        nextIrq;
    wrapNow  = mTcon[0] && (mTl == 32'hFFFF_FFFF);
    raise    = wrapNow && mTcon[1];
    nextIrq  = mTcon[1] && mTcon[2];
    nextTl   = mTcon[0] ? (wrapNow ? mTh : mTl + 32'd1) : mTl;
    nextTcon = mTcon | {raise, 2'b00};
    if (w && a[31:8] == BASE[31:8]) begin
      case (a[7:0] & 8'hFC)
        8'h00: mTh = d;
        8'h04: nextTl = d;
        8'h08: nextTcon = {d[2] | raise, d[1:0]};
        8'h0C: mLed = d[7:0];
        8'h14: mDigi = d[11:0];
        default: ;
      endcase
    end
    mTl   = nextTl;
    mTcon = nextTcon;
    mIrq  = nextIrq;
    mTick = mTick + 32'd1;
    mSw   = sw;
  endtask

  // Performs one bus cycle.
  // It is called at posedge+1, samples rdata at the negedge, and returns at the
  // next posedge+1 with the model advanced.
  task automatic busStep(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d);
    rd = r; wr = w; addr = a; wdata = d;
    @(negedge clk);
    sampledRdata = rdata;
    expRdata     = modelRead(r, a);
    @(posedge clk);
    modelEdge(w, a, d, switch);
    #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; switch = 8'h3C; rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      addr = BASE + 32'(i * 4);
      #1;
      checks++;
      if (rdata !== 32'h0) begin
        failures++;
        $display("[TB] FAIL reset_read off=%h got=%h exp=0", i * 4, rdata);
      end
    end
    rd = 1'b0;
    checks++;
    if (irqout !== 1'b0 || led !== 8'h0 || digi !== 12'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs irq=%b led=%h digi=%h exp=0", irqout, led, digi);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    modelReset();
    for (int i = 0; i < 7; i++) begin
      busStep(1'b1, 1'b0, BASE + 32'(i * 4), 32'h0);
      checks++;
      if (sampledRdata !== expRdata) begin
        failures++;
        $display("[TB] FAIL post_reset_read off=%h got=%h exp=%h", i * 4, sampledRdata, expRdata);
      end
    end
    checks++;
    if (irqout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL post_reset_irq got=%b exp=0", irqout);
    end
  endtask

  task automatic test_timer_overflow();
    busStep(1'b0, 1'b1, A_TH,   32'hFFFF_B4C0);
    busStep(1'b0, 1'b1, A_TL,   32'hFFFF_FFFF);
    busStep(1'b0, 1'b1, A_TCON, 32'h3);
    busStep(1'b1, 1'b0, A_TL,   32'h0);
    checks++;
    if (sampledRdata !== 32'hFFFF_FFFF || irqout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_pre tl=%h irq=%b exp tl=ffffffff irq=0", sampledRdata, irqout);
    end
    busStep(1'b1, 1'b0, A_TL, 32'h0);
    checks++;
    if (sampledRdata !== 32'hFFFF_B4C0) begin
      failures++;
      $display("[TB] FAIL ovf_reload got=%h exp=ffffb4c0", sampledRdata);
    end
    checks++;
    if (irqout !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_irq got=%b exp=1", irqout);
    end
    busStep(1'b1, 1'b0, A_TCON, 32'h0);
    checks++;
    if (sampledRdata !== 32'h7) begin
      failures++;
      $display("[TB] FAIL ovf_tcon got=%h exp=7", sampledRdata);
    end
    busStep(1'b1, 1'b0, A_TL, 32'h0);
    checks++;
    if (sampledRdata !== 32'hFFFF_B4C2 || sampledRdata !== expRdata) begin
      failures++;
      $display("[TB] FAIL ovf_count got=%h exp=ffffb4c2 model=%h", sampledRdata, expRdata);
    end
  endtask

  task automatic test_ack_and_freeze();
    logic [31:0] v1, v2;
    busStep(1'b0, 1'b1, A_TCON, 32'h1);
    busStep(1'b1, 1'b0, A_TL, 32'h0);
    v1 = sampledRdata;
    checks++;
    if (irqout !== 1'b0 || irqout !== mIrq) begin
      failures++;
      $display("[TB] FAIL ack_irq got=%b exp=0", irqout);
    end
    busStep(1'b1, 1'b0, A_TL, 32'h0);
    v2 = sampledRdata;
    checks++;
    if (v2 !== v1 + 32'd1 || v2 !== expRdata) begin
      failures++;
      $display("[TB] FAIL ack_counting got=%h exp=%h", v2, v1 + 32'd1);
    end
    busStep(1'b0, 1'b1, A_TCON, 32'h0);
    busStep(1'b1, 1'b0, A_TL, 32'h0);
    v1 = sampledRdata;
    busStep(1'b1, 1'b0, A_TL, 32'h0);
    v2 = sampledRdata;
    checks++;
    if (v2 !== v1 || v2 !== expRdata) begin
      failures++;
      $display("[TB] FAIL freeze got=%h exp=%h", v2, v1);
    end
  endtask

  task automatic test_io();
    switch = 8'hA5;
    busStep(1'b0, 1'b0, 32'h0, 32'h0);
    busStep(1'b0, 1'b0, 32'h0, 32'h0);
    busStep(1'b1, 1'b0, A_SW, 32'h0);
    checks++;
    if (sampledRdata !== 32'hA5) begin
      failures++;
      $display("[TB] FAIL switch_read got=%h exp=a5", sampledRdata);
    end
    busStep(1'b0, 1'b1, A_LED, 32'h0F);
    checks++;
    if (led !== 8'h0F) begin
      failures++;
      $display("[TB] FAIL led_write got=%h exp=0f", led);
    end
    busStep(1'b0, 1'b1, A_DIGI, 32'h240);
    checks++;
    if (digi !== 12'h240) begin
      failures++;
      $display("[TB] FAIL digi_write got=%h exp=240", digi);
    end
  endtask

  task automatic test_rd_wr_same();
    busStep(1'b1, 1'b1, A_LED, 32'h5A);
    checks++;
    if (sampledRdata !== 32'h0F || led !== 8'h5A) begin
      failures++;
      $display("[TB] FAIL rd_wr_same rdata=%h led=%h exp rdata=0f led=5a", sampledRdata, led);
    end
  endtask

  task automatic test_overflow_collision();
    busStep(1'b0, 1'b1, A_TL,   32'hFFFF_FFFE);
    busStep(1'b0, 1'b1, A_TCON, 32'h3);
    busStep(1'b0, 1'b0, 32'h0,  32'h0);
    busStep(1'b0, 1'b1, A_TCON, 32'h3);
    busStep(1'b1, 1'b0, A_TCON, 32'h0);
    checks++;
    if (sampledRdata !== 32'h7) begin
      failures++;
      $display("[TB] FAIL collide_tcon got=%h exp=7", sampledRdata);
    end
    checks++;
    if (irqout !== 1'b1) begin
      failures++;
      $display("[TB] FAIL collide_irq got=%b exp=1", irqout);
    end
  endtask

  task automatic test_random();
    logic        r, w;
    logic [31:0] a, d;
    int          off;
    for (int n = 0; n < 400; n++) begin
      switch = 8'($urandom);
      r   = 1'($urandom);
      w   = ($urandom_range(0, 2) != 0);
      off = $urandom_range(0, 7);
      a   = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = a ^ (32'h1 << $urandom_range(8, 31));
      if ($urandom_range(0, 19) == 0) a = BASE + 32'($urandom_range(8, 63) * 4);
      d = $urandom;
      if (off == 1 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
      if (off == 0) d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      if (off == 2) d = {29'h0, 3'($urandom)};
      busStep(r, w, a, d);
      checks++;
      if (sampledRdata !== expRdata) begin
        failures++;
        $display("[TB] FAIL rand_rdata n=%0d addr=%h got=%h exp=%h", n, a, sampledRdata, expRdata);
      end
      checks++;
      if (irqout !== mIrq) begin
        failures++;
        $display("[TB] FAIL rand_irq n=%0d got=%b exp=%b", n, irqout, mIrq);
      end
      checks++;
      if (led !== mLed || digi !== mDigi) begin
        failures++;
        $display("[TB] FAIL rand_io n=%0d led=%h/%h digi=%h/%h", n, led, mLed, digi, mDigi);
      end
    end
  endtask

  task automatic test_async_reset();
    int waited;
    busStep(1'b0, 1'b1, A_TH,   32'hFFFF_FFF0);
    busStep(1'b0, 1'b1, A_TL,   32'hFFFF_FFFD);
    busStep(1'b0, 1'b1, A_TCON, 32'h3);
    waited = 0;
    while (irqout !== 1'b1 && waited < 20) begin
      busStep(1'b0, 1'b0, 32'h0, 32'h0);
      waited++;
    end
    checks++;
    if (irqout !== 1'b1 || mIrq !== 1'b1) begin
      failures++;
      $display("[TB] FAIL arst_setup irq=%b model=%b after %0d cycles", irqout, mIrq, waited);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (irqout !== 1'b0 || led !== 8'h0 || digi !== 12'h0) begin
      failures++;
      $display("[TB] FAIL arst_outputs irq=%b led=%h digi=%h exp=0", irqout, led, digi);
    end
    rd = 1'b1;
    for (int i = 0; i < 7; i++) begin
      addr = BASE + 32'(i * 4);
      #1;
      checks++;
      if (rdata !== 32'h0) begin
        failures++;
        $display("[TB] FAIL arst_read off=%h got=%h exp=0", i * 4, rdata);
      end
    end
    rd = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    modelReset();
    busStep(1'b1, 1'b0, A_TICK, 32'h0);
    checks++;
    if (sampledRdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL tick_restart0 got=%h exp=0", sampledRdata);
    end
    busStep(1'b1, 1'b0, A_TICK, 32'h0);
    checks++;
    if (sampledRdata !== 32'h1) begin
      failures++;
      $display("[TB] FAIL tick_restart1 got=%h exp=1", sampledRdata);
    end
    busStep(1'b1, 1'b0, A_TL, 32'h0);
    checks++;
    if (sampledRdata !== 32'h0 || sampledRdata !== expRdata) begin
      failures++;
      $display("[TB] FAIL timer_stays_off got=%h exp=0", sampledRdata);
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_timer_overflow();
    test_ack_and_freeze();
    test_io();
    test_rd_wr_same();
    test_overflow_collision();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
